// File: rtl/tx_sender.sv
// Byte-to-FIFO transmit sender with parity, full-flag backpressure and timeout drop.
// Optional parity bit in fifo_data[8] is enabled by defining TX_PARITY_EN.
module tx_sender #(
   parameter int PARITY_ODD = 0,
   parameter int TIMEOUT    = 1023
) (
   input  logic        baud_clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        send,
   output logic        ready,
   input  logic        TxFF,
   output logic        wr_en,
   output logic [8:0]  fifo_data,
   output logic        drop,
   output logic [15:0] sent_cnt,
   output logic [7:0]  drop_cnt
);

   // state | meaning
   // IDLE  | ready for a new byte
   // LOAD  | word held, first push attempt
   // WAIT  | FIFO was full, retrying until push or timeout drop
   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state;
   logic [8:0]    hold;
   logic [CW-1:0] wait_cnt;
   logic          par_bit;

`ifdef TX_PARITY_EN
   assign par_bit = (^data_in) ^ (PARITY_ODD != 0);
`else
   assign par_bit = 1'b0;
`endif

   assign fifo_data = hold;
   assign ready     = !rst && (state == IDLE);
   assign wr_en     = !rst && (state != IDLE) && !TxFF;

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         state    <= IDLE;
         hold     <= 9'd0;
         wait_cnt <= '0;
         sent_cnt <= 16'd0;
         drop_cnt <= 8'd0;
         drop     <= 1'b0;
      end else begin
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (send) begin
                  hold  <= {par_bit, data_in};
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (!TxFF) begin
                  sent_cnt <= sent_cnt + 16'd1;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // a push on the expiring cycle wins over the drop
               if (!TxFF) begin
                  sent_cnt <= sent_cnt + 16'd1;
                  state    <= IDLE;
               end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_TC)) begin
                  drop     <= 1'b1;
                  drop_cnt <= drop_cnt + 8'd1;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tx_sender.md
TX_SENDER -- requirements
Module: tx_sender

Interface
REQ-001 Parameter PARITY_ODD, default 0: the block SHALL generate odd parity when 1 and even parity when 0.
REQ-002 Parameter TIMEOUT, default 1023: the block SHALL wait at most this many cycles while the FIFO reports full before dropping the held word; 0 SHALL disable dropping.
REQ-003 Port baud_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high; clock baud_clk.
REQ-005 Port data_in, input, 8 bits: user byte to transmit.
REQ-006 Port send, input, 1 bit: user transmit request, sampled only while ready=1.
REQ-007 Port ready, output, 1 bit: block can accept a byte this cycle.
REQ-008 Port TxFF, input, 1 bit: Tx FIFO full flag.
REQ-009 Port wr_en, output, 1 bit: Tx FIFO push strobe.
REQ-010 Port fifo_data, output, 9 bits: Tx FIFO word, [8]=parity bit, [7:0]=data.
REQ-011 Port drop, output, 1 bit: one-cycle pulse when a held word is discarded on timeout.
REQ-012 Port sent_cnt, output, 16 bits: count of words pushed.
REQ-013 Port drop_cnt, output, 8 bits: count of words dropped.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD and WAIT.
REQ-015 In IDLE, ready SHALL be 1; in LOAD and WAIT, ready SHALL be 0.
REQ-016 In IDLE with send=1, the block SHALL capture data_in and its parity into a 9-bit hold register and go to LOAD at the next edge.
REQ-017 In IDLE with send=0, the FSM SHALL stay in IDLE.
REQ-018 send asserted while ready=0 SHALL be ignored; no capture and no queueing.
REQ-019 fifo_data SHALL always equal the hold register.
REQ-020 wr_en SHALL be combinational: 1 exactly when the state is LOAD or WAIT, TxFF=0 and rst=0.
REQ-021 In LOAD or WAIT with TxFF=0, the block SHALL push (wr_en=1 for exactly that cycle), increment sent_cnt and return to IDLE.
REQ-022 In LOAD with TxFF=1, the FSM SHALL go to WAIT and clear the wait counter.
REQ-023 In WAIT with TxFF=1, the wait counter SHALL increment each cycle.
REQ-024 In WAIT, when the wait counter reaches TIMEOUT-1 with TxFF=1 and TIMEOUT is not 0, the block SHALL pulse drop for one cycle, increment drop_cnt, return to IDLE and leave sent_cnt unchanged.
REQ-025 When TxFF falls on the same cycle the timeout would expire, the push SHALL take priority over the drop.
REQ-026 Latency SHALL be fixed: send at edge N produces wr_en=1 in cycle N+1 when the FIFO is not full.
REQ-027 Peak throughput SHALL be one word per 2 cycles.
REQ-028 sent_cnt and drop_cnt SHALL wrap modulo 2^16 and 2^8 respectively, with no saturation.
REQ-029 Parity SHALL be computed as XOR of data_in[7:0] XOR PARITY_ODD, evaluated at capture time.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, hold register=0, wait counter=0, sent_cnt=0, drop_cnt=0 and drop=0.
REQ-031 While rst=1, wr_en SHALL be 0 and ready SHALL be 0.
REQ-032 Reset in LOAD or WAIT SHALL discard the held word with no push and no drop count.
REQ-033 In the first cycle after rst deasserts, ready SHALL be 1.

Configuration
REQ-034 With macro TX_PARITY_EN defined, fifo_data[8] SHALL carry the parity defined in REQ-029.
REQ-035 With TX_PARITY_EN undefined, fifo_data[8] SHALL be constant 0 and PARITY_ODD SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-036 The bench SHALL check, with TX_PARITY_EN and PARITY_ODD=0, that send with data_in=0xA5 and TxFF=0 gives wr_en=1 next cycle with fifo_data=0x0A5 and sent_cnt=1.
REQ-037 The bench SHALL check that 0x07 with PARITY_ODD=0 gives fifo_data=0x107, and 0xA5 with PARITY_ODD=1 gives 0x1A5; without TX_PARITY_EN, 0x07 gives 0x007.
REQ-038 The bench SHALL check, with TxFF=1 for 5 cycles after capture and then 0 (TIMEOUT=1023), exactly one wr_en pulse on the first TxFF=0 cycle, drop=0 and ready=1 afterwards.
REQ-039 The bench SHALL check, with TIMEOUT=4 and TxFF held at 1, a single drop pulse, drop_cnt=1, no wr_en and a return to IDLE.
REQ-040 The bench SHALL check that send held high continuously for 6 cycles with TxFF=0 yields 3 pushes on alternate cycles and sent_cnt=3.
REQ-041 The bench SHALL check that rst asserted during WAIT gives no wr_en, all counters 0 and ready=1 one cycle after rst deasserts.
